// File: rtl/multicycle_mem_responder_if.sv
// rtl/multicycle_mem_responder_if.sv - request/response bus between the multicycle CPU and its memory
interface multicycle_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/multicycle_mem_responder.sv
// rtl/multicycle_mem_responder.sv - unified word memory with fixed-latency single-outstanding responses
// Optional MEM_MISALIGN_CHECK_EN: flag and suppress accesses with nonzero byte offset.
module multicycle_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_mem_responder_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1) begin : g_bad_latency
    $error("multicycle_mem_responder: LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic                   we_q;
  logic                   mis_q;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   accept;
  logic                   commit;
  logic                   mis_in;
  logic                   unused_addr;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_in = |bus.req_addr[1:0];
`else
  assign mis_in = 1'b0;
`endif

  // Upper bits alias and offset bits are only looked at by the optional check.
  assign unused_addr = ^{bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};

  assign accept = bus.req_valid && (state == IDLE);
  assign commit = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = BUSY;
      BUSY:    if (cnt == '0) state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_W'(LATENCY - 1);
        we_q    <= bus.req_we;
        mis_q   <= mis_in;
        idx     <= bus.req_addr[ADDR_WIDTH+1:2];
        wdata_q <= bus.req_wdata;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rdata_q <= (we_q || mis_q) ? '0 : mem[idx];
        err_q   <= mis_q;
      end
    end
  end

  // Write lands only on the BUSY->RESP edge, so a reset while BUSY drops it.
  always_ff @(posedge clk) begin
    if (commit && we_q && !mis_q) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb/tb_multicycle_mem_responder.sv - self-checking bench for multicycle_mem_responder
module tb_multicycle_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  multicycle_mem_responder_if #(.DATA_WIDTH(32)) m0 ();
  multicycle_mem_responder_if #(.DATA_WIDTH(32)) m1 ();

  multicycle_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(3)) u0 (
    .clk(clk), .reset(reset), .bus(m0));
  multicycle_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .bus(m1));

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [1024];
  bit          known   [1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request on m0; hold = cycles the response is left unconsumed, keep_valid = keep req_valid high meanwhile.
  task automatic xact(input string tag, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, input bit keep_valid,
                      output logic [31:0] rd, output logic err);
    int lat;
    chk({tag, "_ready"}, {31'd0, m0.req_ready}, 32'd1);
    m0.req_valid = 1'b1; m0.req_we = we; m0.req_addr = addr; m0.req_wdata = wd;
    @(posedge clk); #1;
    m0.req_valid = keep_valid;
    m0.req_we    = 1'($urandom);
    m0.req_addr  = $urandom;
    m0.req_wdata = $urandom;
    lat = 0;
    while (m0.resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd3);
    rd  = m0.resp_rdata;
    err = m0.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_flags"}, {29'd0, m0.resp_valid, m0.req_ready, m0.busy}, 32'b101);
      chk({tag, "_hold_data"}, {m0.resp_rdata}, rd);
    end
    m0.resp_ready = 1'b1;
    @(posedge clk); #1;
    m0.resp_ready = 1'b0;
    chk({tag, "_done_flags"}, {29'd0, m0.resp_valid, m0.req_ready, m0.busy}, 32'b010);
    if (keep_valid) begin
      m0.req_valid = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_no_second_accept"}, {31'd0, m0.busy}, 32'd0);
    end
  endtask

  task automatic model_xact(input string tag, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input int hold, input bit keep_valid);
    logic [31:0] rd;
    logic        err;
    int          w;
    bit          mis;
    w   = int'((addr >> 2) % 1024);
    mis = MIS_EN && (addr % 4 != 0);
    xact(tag, we, addr, wd, hold, keep_valid, rd, err);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, mis});
    if (we) begin
      chk({tag, "_store_rdata"}, rd, 32'd0);
      if (!mis) begin
        ref_mem[w] = wd;
        known[w]   = 1'b1;
      end
    end else if (mis) begin
      chk({tag, "_misaligned_rdata"}, rd, 32'd0);
    end else if (known[w]) begin
      chk({tag, "_load_rdata"}, rd, ref_mem[w]);
    end
  endtask

  initial begin
    reset = 1'b0;
    m0.req_valid = 1'b0; m0.req_we = 1'b0; m0.req_addr = '0; m0.req_wdata = '0; m0.resp_ready = 1'b0;
    m1.req_valid = 1'b0; m1.req_we = 1'b0; m1.req_addr = '0; m1.req_wdata = '0; m1.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {29'd0, m0.resp_valid, m0.req_ready, m0.busy}, 32'b010);
    chk("reset_rdata", m0.resp_rdata, 32'd0);
    chk("reset_err", {31'd0, m0.resp_err}, 32'd0);
    chk("reset_flags_l1", {29'd0, m1.resp_valid, m1.req_ready, m1.busy}, 32'b010);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    model_xact("t1_store", 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    model_xact("t1_load", 1'b0, 32'h10, 32'h0, 0, 1'b0);

    model_xact("t2_stall", 1'b0, 32'h10, 32'h0, 5, 1'b1);

    model_xact("t3_store", 1'b1, 32'h0, 32'h1, 0, 1'b0);
    model_xact("t3_alias", 1'b0, 32'h1000, 32'h0, 0, 1'b0);

    model_xact("t4_pre_store", 1'b1, 32'h20, 32'h5, 0, 1'b0);
    model_xact("t4_pre_load", 1'b0, 32'h20, 32'h0, 0, 1'b0);
    m0.req_valid = 1'b1; m0.req_we = 1'b1; m0.req_addr = 32'h20; m0.req_wdata = 32'h7;
    @(posedge clk); #1;
    m0.req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t4_reset_flags", {29'd0, m0.resp_valid, m0.req_ready, m0.busy}, 32'b010);
    chk("t4_reset_rdata", m0.resp_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    model_xact("t4_after_reset", 1'b0, 32'h20, 32'h0, 0, 1'b0);

    model_xact("t5_store_mis", 1'b1, 32'h22, 32'hAA, 0, 1'b0);
    model_xact("t5_load", 1'b0, 32'h20, 32'h0, 0, 1'b0);
    model_xact("t5_load_mis", 1'b0, 32'h23, 32'h0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) << 2) |
          (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      model_xact("rand", 1'($urandom), a, $urandom, $urandom_range(0, 3), 1'b0);
    end

    m1.resp_ready = 1'b1;
    m1.req_valid  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("t6_resp_valid", {31'd0, m1.resp_valid}, {31'd0, (k % 3 == 2)});
      chk("t6_req_ready", {31'd0, m1.req_ready}, {31'd0, (k % 3 == 0)});
    end
    m1.req_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
